// File: rtl/wisc_pkg.sv
// Shared fetch-stage types: NOP encoding, fetch FSM states and the IF/ID bundle.
package wisc_pkg;

    localparam int unsigned WORD_W = 16;
    localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc2;
        logic              valid;
    } ifid_t;

endpackage

// File: rtl/cla16b.sv
// 16-bit carry-lookahead adder (4-bit lookahead groups), wraps modulo 2^16.
module cla16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);
    logic [15:0] p;
    logic [15:0] c;
    logic [14:0] g;
    logic [3:0]  gc;

    assign p     = a ^ b;
    assign g     = a[14:0] & b[14:0];
    assign gc[0] = cin;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int B = 4 * k;
        assign c[B]   = gc[k];
        assign c[B+1] = g[B] | (p[B] & gc[k]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & gc[k]);
        // The top group's carry-out is dropped, so only groups 0..2 need a lookahead term.
        if (k < 3) begin : g_la
            assign gc[k+1] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                           | (p[B+3] & p[B+2] & p[B+1] & g[B])
                           | (p[B+3] & p[B+2] & p[B+1] & p[B] & gc[k]);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/fetch_skid.sv
// One-entry skid buffer for the IF/ID bundle; clear wins over load, load over unload.
module fetch_skid
    import wisc_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_i,
    input  logic  unload_i,
    input  logic  clear_i,
    input  ifid_t entry_i,
    output ifid_t entry_o,
    output logic  full_o
);
    ifid_t entry_q;
    logic  full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            entry_q <= '{instr: NOP_INSTR, pc2: '0, valid: 1'b0};
        end else if (clear_i) begin
            full_q  <= 1'b0;
            entry_q <= '{instr: NOP_INSTR, pc2: '0, valid: 1'b0};
        end else if (load_i) begin
            full_q  <= 1'b1;
            entry_q <= entry_i;
        end else if (unload_i) begin
            full_q  <= 1'b0;
        end
    end

    assign entry_o = entry_q;
    assign full_o  = full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC -> imem handshake -> IF/ID register, one cycle after ImemDone.
// Decode stalls park one response in a skid entry; requests pause while it is occupied.
module fetch_stage
    import wisc_pkg::*;
#(
    parameter int unsigned     AW  = 16,
    parameter logic [AW-1:0]   NOP = NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] FetchPc,
    input  logic          Stall,
    input  logic          Flush,
    input  logic          Halt,
    output logic          ImemReq,
    output logic [AW-1:0] ImemAddr,
    input  logic          ImemDone,
    input  logic [AW-1:0] ImemData,
    output logic          FetchStall,
    output logic [AW-1:0] IfIdInstr,
    output logic [AW-1:0] IfIdPc2,
    output logic          IfIdValid,
    output logic          Err
);
    fetch_state_t  state_q;
    ifid_t         ifid_q, ifid_d, skid_entry, fetched, bubble;
    logic          err_q;
    logic [AW-1:0] drain_addr_q;
    logic [AW-1:0] pc2;
    logic          skid_full, skid_load, skid_unload, skid_clear;
    logic          in_fetch, misaligned, req, resp;

    assign in_fetch   = (state_q == FETCH);
    assign misaligned = in_fetch & FetchPc[0];
    assign req        = (in_fetch & ~skid_full & ~FetchPc[0]) | (state_q == DRAIN);
    assign resp       = req & ImemDone;

    assign ImemReq    = req;
    // A drain keeps presenting the squashed address even though the pc stage has already redirected.
    assign ImemAddr   = (state_q == DRAIN) ? drain_addr_q : FetchPc;
    assign FetchStall = ~(in_fetch & resp);

    cla16b u_pc2_add (
        .a   (FetchPc),
        .b   (16'h0002),
        .cin (1'b0),
        .sum (pc2)
    );

    assign fetched = '{instr: ImemData, pc2: pc2, valid: 1'b1};
    assign bubble  = '{instr: NOP, pc2: ifid_q.pc2, valid: 1'b0};

    always_comb begin
        ifid_d      = ifid_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
        if (Flush || misaligned) begin
            ifid_d     = bubble;
            skid_clear = 1'b1;
        end else if (skid_full) begin
            if (!Stall) begin
                ifid_d      = skid_entry;
                skid_unload = 1'b1;
            end
        end else if (in_fetch && resp) begin
            if (Stall && ifid_q.valid) skid_load = 1'b1;
            else                       ifid_d    = fetched;
        end else if (!Stall) begin
            ifid_d = bubble;
        end
    end

    fetch_skid u_skid (
        .clk      (clk),
        .rst_n    (rst),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .entry_i  (fetched),
        .entry_o  (skid_entry),
        .full_o   (skid_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ifid_q       <= '{instr: NOP, pc2: '0, valid: 1'b0};
            err_q        <= 1'b0;
            drain_addr_q <= '0;
        end else begin
            ifid_q <= ifid_d;
            case (state_q)
                IDLE: state_q <= Halt ? HALTED : FETCH;
                FETCH: begin
                    if (FetchPc[0]) begin
                        err_q   <= 1'b1;
                        state_q <= HALTED;
                    end else if (Flush && req && !ImemDone) begin
                        state_q      <= DRAIN;
                        drain_addr_q <= FetchPc;
                    end else if (Halt && (!req || ImemDone)) begin
                        state_q <= HALTED;
                    end
                end
                DRAIN: if (ImemDone) state_q <= Halt ? HALTED : FETCH;
                default: state_q <= HALTED;
            endcase
        end
    end

    assign IfIdInstr = ifid_q.instr;
    assign IfIdPc2   = ifid_q.pc2;
    assign IfIdValid = ifid_q.valid;
    assign Err       = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Cycle-table bench for fetch_stage with a scoreboard of expected {instr, pc2} pairs.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] FetchPc;
    logic        Stall, Flush, Halt;
    logic        ImemReq;
    logic [15:0] ImemAddr;
    logic        ImemDone;
    logic [15:0] ImemData;
    logic        FetchStall;
    logic [15:0] IfIdInstr, IfIdPc2;
    logic        IfIdValid, Err;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];

    // ctl = {stall, flush, halt, done, acc}; exp = {req, fetchstall, ifid_valid, err}
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
        logic [4:0]  ctl;
        logic [3:0]  exp;
        logic [15:0] addr;
    } stim_t;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .FetchPc    (FetchPc),
        .Stall      (Stall),
        .Flush      (Flush),
        .Halt       (Halt),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemDone   (ImemDone),
        .ImemData   (ImemData),
        .FetchStall (FetchStall),
        .IfIdInstr  (IfIdInstr),
        .IfIdPc2    (IfIdPc2),
        .IfIdValid  (IfIdValid),
        .Err        (Err)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; FetchPc = 16'h0000; Stall = 1'b0; Flush = 1'b0; Halt = 1'b0;
        ImemDone = 1'b0; ImemData = 16'h0000;
        #2 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ImemReq, FetchStall, IfIdValid, Err} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_ctl req/fs/vld/err=%b%b%b%b want 0100", ImemReq, FetchStall, IfIdValid, Err);
        end
        checks++;
        if ({IfIdInstr, IfIdPc2} !== {16'h0800, 16'h0000}) begin
            errors++;
            $display("FAIL reset_ifid instr=%h pc2=%h want 0800 0000", IfIdInstr, IfIdPc2);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ImemReq !== 1'b0) begin
            errors++;
            $display("FAIL idle_req req=%b want 0", ImemReq);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({ImemReq, ImemAddr} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL first_req req=%b addr=%h want 1 0000", ImemReq, ImemAddr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_latency();
        stim_t t [8];
        t = '{'{16'h0000, 16'h1234, 5'b00011, 4'b1000, 16'h0000},
              '{16'h0002, 16'h5678, 5'b00011, 4'b1010, 16'h0002},
              '{16'h0004, 16'h0000, 5'b00000, 4'b1110, 16'h0004},
              '{16'h0010, 16'h0000, 5'b00000, 4'b1100, 16'h0010},
              '{16'h0010, 16'h0000, 5'b00000, 4'b1100, 16'h0010},
              '{16'h0010, 16'h0000, 5'b00000, 4'b1100, 16'h0010},
              '{16'h0010, 16'hABCD, 5'b00011, 4'b1000, 16'h0010},
              '{16'h0012, 16'h0000, 5'b00000, 4'b1110, 16'h0012}};
        for (int i = 0; i < 8; i++) begin
            {Stall, Flush, Halt, ImemDone} = t[i].ctl[4:1];
            FetchPc = t[i].pc; ImemData = t[i].data;
            @(negedge clk);
            checks++;
            if ({ImemReq, FetchStall, IfIdValid, Err} !== t[i].exp) begin
                errors++;
                $display("FAIL latency_ctl c%0d req/fs/vld/err=%b%b%b%b want %b", i, ImemReq, FetchStall, IfIdValid, Err, t[i].exp);
            end
            if (t[i].exp[3]) begin
                checks++;
                if (ImemAddr !== t[i].addr) begin
                    errors++;
                    $display("FAIL latency_addr c%0d addr=%h want %h", i, ImemAddr, t[i].addr);
                end
            end
            if (t[i].exp[1]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL latency_sb c%0d unexpected instr=%h", i, IfIdInstr);
                end else if ({IfIdInstr, IfIdPc2} !== sb[0]) begin
                    errors++;
                    $display("FAIL latency_ifid c%0d instr/pc2=%h/%h want %h", i, IfIdInstr, IfIdPc2, sb[0]);
                end
                if (!Stall && sb.size() != 0) void'(sb.pop_front());
            end
            if (t[i].ctl[3]) sb.delete();
            if (t[i].ctl[0]) sb.push_back({t[i].data, t[i].pc + 16'd2});
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back_stall();
        stim_t t [6];
        t = '{'{16'h0012, 16'h1111, 5'b00011, 4'b1000, 16'h0012},
              '{16'h0014, 16'h2222, 5'b10011, 4'b1010, 16'h0014},
              '{16'h0016, 16'h0000, 5'b10000, 4'b0110, 16'h0000},
              '{16'h0016, 16'h0000, 5'b00000, 4'b0110, 16'h0000},
              '{16'h0016, 16'h3333, 5'b00011, 4'b1010, 16'h0016},
              '{16'h0018, 16'h0000, 5'b00000, 4'b1110, 16'h0018}};
        for (int i = 0; i < 6; i++) begin
            {Stall, Flush, Halt, ImemDone} = t[i].ctl[4:1];
            FetchPc = t[i].pc; ImemData = t[i].data;
            @(negedge clk);
            checks++;
            if ({ImemReq, FetchStall, IfIdValid, Err} !== t[i].exp) begin
                errors++;
                $display("FAIL skid_ctl c%0d req/fs/vld/err=%b%b%b%b want %b", i, ImemReq, FetchStall, IfIdValid, Err, t[i].exp);
            end
            if (t[i].exp[3]) begin
                checks++;
                if (ImemAddr !== t[i].addr) begin
                    errors++;
                    $display("FAIL skid_addr c%0d addr=%h want %h", i, ImemAddr, t[i].addr);
                end
            end
            if (t[i].exp[1]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL skid_sb c%0d unexpected instr=%h", i, IfIdInstr);
                end else if ({IfIdInstr, IfIdPc2} !== sb[0]) begin
                    errors++;
                    $display("FAIL skid_ifid c%0d instr/pc2=%h/%h want %h", i, IfIdInstr, IfIdPc2, sb[0]);
                end
                if (!Stall && sb.size() != 0) void'(sb.pop_front());
            end
            if (t[i].ctl[3]) sb.delete();
            if (t[i].ctl[0]) sb.push_back({t[i].data, t[i].pc + 16'd2});
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        stim_t t [9];
        t = '{'{16'h0020, 16'h0000, 5'b00000, 4'b1100, 16'h0020},
              '{16'h0020, 16'h0000, 5'b01000, 4'b1100, 16'h0020},
              '{16'h0040, 16'h0000, 5'b00000, 4'b1100, 16'h0020},
              '{16'h0040, 16'hDEAD, 5'b00010, 4'b1100, 16'h0020},
              '{16'h0040, 16'h0000, 5'b00000, 4'b1100, 16'h0040},
              '{16'h0040, 16'h4444, 5'b00011, 4'b1000, 16'h0040},
              '{16'h0042, 16'h0000, 5'b10000, 4'b1110, 16'h0042},
              '{16'h0042, 16'h5555, 5'b11010, 4'b1010, 16'h0042},
              '{16'h0044, 16'h0000, 5'b00000, 4'b1100, 16'h0044}};
        for (int i = 0; i < 9; i++) begin
            {Stall, Flush, Halt, ImemDone} = t[i].ctl[4:1];
            FetchPc = t[i].pc; ImemData = t[i].data;
            @(negedge clk);
            checks++;
            if ({ImemReq, FetchStall, IfIdValid, Err} !== t[i].exp) begin
                errors++;
                $display("FAIL flush_ctl c%0d req/fs/vld/err=%b%b%b%b want %b", i, ImemReq, FetchStall, IfIdValid, Err, t[i].exp);
            end
            if (t[i].exp[3]) begin
                checks++;
                if (ImemAddr !== t[i].addr) begin
                    errors++;
                    $display("FAIL flush_addr c%0d addr=%h want %h", i, ImemAddr, t[i].addr);
                end
            end
            if (t[i].exp[1]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL flush_sb c%0d unexpected instr=%h", i, IfIdInstr);
                end else if ({IfIdInstr, IfIdPc2} !== sb[0]) begin
                    errors++;
                    $display("FAIL flush_ifid c%0d instr/pc2=%h/%h want %h", i, IfIdInstr, IfIdPc2, sb[0]);
                end
                if (!Stall && sb.size() != 0) void'(sb.pop_front());
            end
            if (t[i].ctl[3]) sb.delete();
            if (t[i].ctl[0]) sb.push_back({t[i].data, t[i].pc + 16'd2});
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap_misalign();
        stim_t t [6];
        t = '{'{16'hFFFE, 16'hBEEF, 5'b00011, 4'b1000, 16'hFFFE},
              '{16'h0000, 16'h0000, 5'b00000, 4'b1110, 16'h0000},
              '{16'h0003, 16'h0000, 5'b00000, 4'b0100, 16'h0000},
              '{16'h0003, 16'h0000, 5'b00000, 4'b0101, 16'h0000},
              '{16'h0004, 16'h0000, 5'b00010, 4'b0101, 16'h0000},
              '{16'h0004, 16'h0000, 5'b00000, 4'b0101, 16'h0000}};
        for (int i = 0; i < 6; i++) begin
            {Stall, Flush, Halt, ImemDone} = t[i].ctl[4:1];
            FetchPc = t[i].pc; ImemData = t[i].data;
            @(negedge clk);
            checks++;
            if ({ImemReq, FetchStall, IfIdValid, Err} !== t[i].exp) begin
                errors++;
                $display("FAIL misalign_ctl c%0d req/fs/vld/err=%b%b%b%b want %b", i, ImemReq, FetchStall, IfIdValid, Err, t[i].exp);
            end
            if (t[i].exp[3]) begin
                checks++;
                if (ImemAddr !== t[i].addr) begin
                    errors++;
                    $display("FAIL misalign_addr c%0d addr=%h want %h", i, ImemAddr, t[i].addr);
                end
            end
            if (t[i].exp[1]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_sb c%0d unexpected instr=%h", i, IfIdInstr);
                end else if ({IfIdInstr, IfIdPc2} !== sb[0]) begin
                    errors++;
                    $display("FAIL wrap_ifid c%0d instr/pc2=%h/%h want %h", i, IfIdInstr, IfIdPc2, sb[0]);
                end
                if (!Stall && sb.size() != 0) void'(sb.pop_front());
            end
            if (t[i].ctl[0]) sb.push_back({t[i].data, t[i].pc + 16'd2});
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt_reset();
        stim_t t [5];
        t = '{'{16'h0030, 16'h0000, 5'b00100, 4'b1100, 16'h0030},
              '{16'h0030, 16'h0000, 5'b00100, 4'b1100, 16'h0030},
              '{16'h0030, 16'h7777, 5'b00111, 4'b1000, 16'h0030},
              '{16'h0032, 16'h0000, 5'b00100, 4'b0110, 16'h0000},
              '{16'h0032, 16'h0000, 5'b00000, 4'b0100, 16'h0000}};
        sb.delete();
        Stall = 1'b0; Flush = 1'b0; Halt = 1'b0; ImemDone = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({ImemReq, FetchStall, IfIdValid, Err} !== 4'b0100) begin
            errors++;
            $display("FAIL rst_clears_err req/fs/vld/err=%b%b%b%b want 0100", ImemReq, FetchStall, IfIdValid, Err);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            {Stall, Flush, Halt, ImemDone} = t[i].ctl[4:1];
            FetchPc = t[i].pc; ImemData = t[i].data;
            @(negedge clk);
            checks++;
            if ({ImemReq, FetchStall, IfIdValid, Err} !== t[i].exp) begin
                errors++;
                $display("FAIL halt_ctl c%0d req/fs/vld/err=%b%b%b%b want %b", i, ImemReq, FetchStall, IfIdValid, Err, t[i].exp);
            end
            if (t[i].exp[1]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL halt_sb c%0d unexpected instr=%h", i, IfIdInstr);
                end else if ({IfIdInstr, IfIdPc2} !== sb[0]) begin
                    errors++;
                    $display("FAIL halt_ifid c%0d instr/pc2=%h/%h want %h", i, IfIdInstr, IfIdPc2, sb[0]);
                end
                if (!Stall && sb.size() != 0) void'(sb.pop_front());
            end
            if (t[i].ctl[0]) sb.push_back({t[i].data, t[i].pc + 16'd2});
            @(posedge clk); #1;
        end
        ImemDone = 1'b1; ImemData = 16'h9999;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({ImemReq, FetchStall, IfIdValid, Err, IfIdInstr, IfIdPc2} !== {4'b0100, 16'h0800, 16'h0000}) begin
            errors++;
            $display("FAIL midcycle_rst req/fs/vld/err=%b%b%b%b instr=%h pc2=%h want 0100 0800 0000",
                     ImemReq, FetchStall, IfIdValid, Err, IfIdInstr, IfIdPc2);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ImemReq, IfIdValid} !== 2'b00) begin
            errors++;
            $display("FAIL late_done_idle req=%b vld=%b want 0 0", ImemReq, IfIdValid);
        end
        @(posedge clk); #1 ImemDone = 1'b0;
        @(negedge clk);
        checks++;
        if ({ImemReq, IfIdValid} !== 2'b10) begin
            errors++;
            $display("FAIL late_done_ignored req=%b vld=%b want 1 0", ImemReq, IfIdValid);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_latency();
        test_back_to_back_stall();
        test_flush();
        test_wrap_misalign();
        test_halt_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover entries=%0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout after 100000 time units");
        $fatal(1);
    end

endmodule
